// File: rtl/lzrw1_pkg.sv
// ---------------------------------------------------------------------------
// lzrw1_pkg
//
// Shared definitions for the LZRW1 match-candidate lookup blocks.
//
// Contents:
//   POS_W       width of an input byte position
//   IDX_W       hash index width; the pointer table holds 2**IDX_W entries
//   MAX_OFFSET  largest match offset the compressor can encode
//   OFF_W       width of the reported offset field
//   state_t     sequencer states
//   ptr_entry_t one pointer-table word: {valid, pos}
//   make_entry  builds a valid table word from a position
// ---------------------------------------------------------------------------
package lzrw1_pkg;

   localparam int POS_W      = 16;
   localparam int IDX_W      = 12;
   localparam int MAX_OFFSET = 4095;
   localparam int OFF_W      = 12;
   localparam int TBL_DEPTH  = 1 << IDX_W;

   // One encoding per phase of a lookup; CLEAR owns the table after reset.
   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_HASH,
      ST_RDATA,
      ST_OUT
   } state_t;

   // A table word. The valid bit separates "never written since the last
   // clear" from a genuine stored position of zero.
   typedef struct packed {
      logic             valid;
      logic [POS_W-1:0] pos;
   } ptr_entry_t;

   // Builds the word written back after every lookup.
   function automatic ptr_entry_t make_entry(input logic [POS_W-1:0] pos);
      ptr_entry_t e;
      e.valid = 1'b1;
      e.pos   = pos;
      return e;
   endfunction

endpackage

// File: rtl/lzrw1_offset_check.sv
// ---------------------------------------------------------------------------
// lzrw1_offset_check
//
// Purely combinational match validation. Given the table word read for a
// key and the current position, produces the candidate position, the
// match offset and whether the candidate is usable as a match.
//
// Ports:
//   entry   in  table word {valid, pos} read for this key
//   pos     in  position of the current key
//   cand    out stored position, forced to 0 when the entry is invalid
//   offset  out low OFF_W bits of (pos - cand), wrapping in POS_W bits
//   hit     out entry valid and 1 <= (pos - cand) <= MAX_OFFSET
// ---------------------------------------------------------------------------
module lzrw1_offset_check
   import lzrw1_pkg::*;
(
   input  ptr_entry_t        entry,
   input  logic [POS_W-1:0]  pos,
   output logic [POS_W-1:0]  cand,
   output logic [OFF_W-1:0]  offset,
   output logic              hit
);

   logic [POS_W-1:0] diff;

   // The subtraction wraps in POS_W bits, so a candidate stored just before
   // the position counter rolled over still yields a small forward distance.
   // A distance of zero would point at the current byte itself and is never
   // a usable match; anything beyond MAX_OFFSET cannot be encoded.
   always_comb begin
      cand   = entry.valid ? entry.pos : '0;
      diff   = pos - cand;
      offset = diff[OFF_W-1:0];
      hit    = entry.valid && (diff != '0) && (diff <= POS_W'(MAX_OFFSET));
   end

endmodule

// File: rtl/lzrw1_hash_ctrl.sv
// ---------------------------------------------------------------------------
// lzrw1_hash_ctrl
//
// Sequencer for the LZRW1 match-candidate lookup. Takes a 3-byte key and
// its position, drives the external combinational hash unit, reads the
// pointer table at the hash index, writes the new position back to the
// same entry and presents the previous position with a validated offset.
// After reset, and on clear_req, it walks the whole table writing zeros.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   clear_req           full table clear request, honoured only in IDLE
//   clear_busy          high while the table is being cleared
//   in_valid/in_ready   key handshake
//   in_key              3 key bytes, [7:0] is the first byte
//   in_pos              position of in_key[7:0]
//   hash_key            key presented to the hash unit (0 when unused)
//   hash_idx            hash unit result, combinational on hash_key
//   tbl_addr            pointer-table address
//   tbl_rd_en           read strobe; tbl_rdata is valid the next cycle
//   tbl_rdata           table read data {valid, pos}
//   tbl_wr_en/tbl_wdata table write strobe and data {valid, pos}
//   out_valid/out_ready result handshake
//   out_pos             echoed key position
//   out_cand            stored position, 0 if the entry was invalid
//   out_offset          low 12 bits of (out_pos - out_cand)
//   out_hit             candidate is a legal match
// ---------------------------------------------------------------------------
module lzrw1_hash_ctrl
   import lzrw1_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [23:0]       in_key,
   input  logic [POS_W-1:0]  in_pos,
   output logic [23:0]       hash_key,
   input  logic [IDX_W-1:0]  hash_idx,
   output logic [IDX_W-1:0]  tbl_addr,
   output logic              tbl_rd_en,
   input  logic [POS_W:0]    tbl_rdata,
   output logic              tbl_wr_en,
   output logic [POS_W:0]    tbl_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POS_W-1:0]  out_pos,
   output logic [POS_W-1:0]  out_cand,
   output logic [OFF_W-1:0]  out_offset,
   output logic              out_hit
);

   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(TBL_DEPTH - 1);

   state_t            state_q;
   state_t            state_d;

   logic [IDX_W-1:0]  cnt_q;
   logic [23:0]       key_q;
   logic [POS_W-1:0]  pos_q;
   logic [IDX_W-1:0]  idx_q;

   logic [POS_W-1:0]  out_pos_q;
   logic [POS_W-1:0]  out_cand_q;
   logic [OFF_W-1:0]  out_offset_q;
   logic              out_hit_q;

   ptr_entry_t        rd_entry;
   ptr_entry_t        wr_entry;
   logic [POS_W-1:0]  chk_cand;
   logic [OFF_W-1:0]  chk_offset;
   logic              chk_hit;

   // The table word returned during RDATA and the word written back in the
   // same cycle. The RAM reads before it writes, so the old entry is seen.
   assign rd_entry = ptr_entry_t'(tbl_rdata);
   assign wr_entry = make_entry(pos_q);

   lzrw1_offset_check u_offset_check (
      .entry  (rd_entry),
      .pos    (pos_q),
      .cand   (chk_cand),
      .offset (chk_offset),
      .hit    (chk_hit)
   );

   // State register. Reset always lands in CLEAR so the table never holds
   // stale pointers from before the reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A clear request in IDLE takes priority over a key
   // offered in the same cycle; the key stays with the producer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
            end else if (in_valid) begin
               state_d = ST_HASH;
            end
         end
         ST_HASH: begin
            state_d = ST_RDATA;
         end
         ST_RDATA: begin
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // Output decode. Every strobe and address is a pure function of the
   // state and the registered datapath, except in_ready (which drops as
   // soon as clear_req is seen) and the HASH-phase address, which comes
   // straight from the combinational hash unit so the read is issued in
   // the same cycle the key is presented.
   always_comb begin
      clear_busy = 1'b0;
      in_ready   = 1'b0;
      hash_key   = '0;
      tbl_addr   = '0;
      tbl_rd_en  = 1'b0;
      tbl_wr_en  = 1'b0;
      tbl_wdata  = '0;
      out_valid  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clear_busy = 1'b1;
            tbl_wr_en  = 1'b1;
            tbl_addr   = cnt_q;
         end
         ST_IDLE: begin
            in_ready = !clear_req;
         end
         ST_HASH: begin
            hash_key  = key_q;
            tbl_rd_en = 1'b1;
            tbl_addr  = hash_idx;
         end
         ST_RDATA: begin
            tbl_wr_en = 1'b1;
            tbl_addr  = idx_q;
            tbl_wdata = wr_entry;
         end
         ST_OUT: begin
            out_valid = 1'b1;
         end
         default: begin
            clear_busy = 1'b0;
         end
      endcase
   end

   // Datapath registers. The clear counter wraps back to zero after the
   // last address, but it is also zeroed explicitly on a clear request so
   // a restart never depends on where it happened to stop. The result
   // registers are loaded once in RDATA and then hold, which keeps out_*
   // stable for however long the consumer stalls in OUT.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         key_q        <= '0;
         pos_q        <= '0;
         idx_q        <= '0;
         out_pos_q    <= '0;
         out_cand_q   <= '0;
         out_offset_q <= '0;
         out_hit_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               cnt_q <= cnt_q + IDX_W'(1);
            end
            ST_IDLE: begin
               if (clear_req) begin
                  cnt_q <= '0;
               end else if (in_valid) begin
                  key_q <= in_key;
                  pos_q <= in_pos;
               end
            end
            ST_HASH: begin
               idx_q <= hash_idx;
            end
            ST_RDATA: begin
               out_pos_q    <= pos_q;
               out_cand_q   <= chk_cand;
               out_offset_q <= chk_offset;
               out_hit_q    <= chk_hit;
            end
            default: begin
               cnt_q <= cnt_q;
            end
         endcase
      end
   end

   assign out_pos    = out_pos_q;
   assign out_cand   = out_cand_q;
   assign out_offset = out_offset_q;
   assign out_hit    = out_hit_q;

endmodule

// File: tb/tb_lzrw1_hash_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lzrw1_hash_ctrl
//
// Directed bench for lzrw1_hash_ctrl. Surrounds the controller with a
// simple xor-fold hash (idx = key[11:0] ^ key[23:12]) so every index below
// can be worked out by hand, and a 4096 x 17 RAM with 1-cycle read that is
// preloaded with junk so the clear is visible.
// ---------------------------------------------------------------------------
module tb_lzrw1_hash_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear_req = 1'b0;
   logic        clear_busy;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_key = '0;
   logic [15:0] in_pos = '0;
   logic [23:0] hash_key;
   logic [11:0] hash_idx;
   logic [11:0] tbl_addr;
   logic        tbl_rd_en;
   logic [16:0] tbl_rdata = '0;
   logic        tbl_wr_en;
   logic [16:0] tbl_wdata;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_pos;
   logic [15:0] out_cand;
   logic [11:0] out_offset;
   logic        out_hit;

   logic [16:0] mem [4096];

   int checks = 0;
   int passes = 0;

   lzrw1_hash_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_key     (in_key),
      .in_pos     (in_pos),
      .hash_key   (hash_key),
      .hash_idx   (hash_idx),
      .tbl_addr   (tbl_addr),
      .tbl_rd_en  (tbl_rd_en),
      .tbl_rdata  (tbl_rdata),
      .tbl_wr_en  (tbl_wr_en),
      .tbl_wdata  (tbl_wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pos    (out_pos),
      .out_cand   (out_cand),
      .out_offset (out_offset),
      .out_hit    (out_hit)
   );

   // Free-running clock; the bench drives and samples on the falling edge.
   always #5 clk = ~clk;

   // Stand-in hash unit: combinational fold of the key.
   assign hash_idx = hash_key[11:0] ^ hash_key[23:12];

   // Stand-in pointer table: synchronous read, write visible next cycle.
   always @(posedge clk) begin
      if (tbl_rd_en) tbl_rdata <= mem[tbl_addr];
      if (tbl_wr_en) mem[tbl_addr] <= tbl_wdata;
   end

   // Junk contents so that a missing clear write is noticed.
   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 17'h15A5A;
   end

   // Hard stop in case some wait is never satisfied.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Presents one key to the controller for the current cycle.
   task automatic applyStimulus(input logic [23:0] key, input logic [15:0] pos);
      in_valid = 1'b1;
      in_key   = key;
      in_pos   = pos;
   endtask

   // Follows a clear from its first cycle (cnt=0) to IDLE, then verifies
   // the cycle count, the address walk and that the table is all zero.
   task automatic wait_clear_done(input string name);
      int n = 0;
      int addr_err = 0;
      int ov_seen = 0;
      int nz = 0;
      while (clear_busy === 1'b1 && n < 5000) begin
         if (tbl_addr !== n[11:0] || tbl_wr_en !== 1'b1 || tbl_wdata !== 17'h0 ||
             in_ready !== 1'b0) addr_err++;
         if (out_valid !== 1'b0) ov_seen++;
         n++;
         @(negedge clk);
      end
      checks++; if (n !== 4096) $display("[TB] FAIL %s clear_cycles: got %0d want 4096", name, n); else passes++;
      checks++; if (addr_err !== 0) $display("[TB] FAIL %s clear_walk: got %0d bad cycles want 0", name, addr_err); else passes++;
      checks++; if (ov_seen !== 0) $display("[TB] FAIL %s clear_out_valid: got %0d cycles want 0", name, ov_seen); else passes++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL %s ready_after_clear: got %b want 1", name, in_ready); else passes++;
      for (int a = 0; a < 4096; a++) if (mem[a] !== 17'h0) nz++;
      checks++; if (nz !== 0) $display("[TB] FAIL %s table_zero: got %0d nonzero want 0", name, nz); else passes++;
   endtask

   // One full lookup with hand-computed expectations. out_ready is held low
   // for 'stall' cycles of OUT (0 means ready from the start).
   task automatic run_key(input string name, input logic [23:0] key, input logic [15:0] pos,
                          input logic [15:0] exp_cand, input logic [11:0] exp_off,
                          input logic exp_hit, input int stall);
      int w = 0;
      logic [11:0] idx;
      idx = key[11:0] ^ key[23:12];
      while (in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         $display("[TB] FAIL %s ready_wait: got %b want 1", name, in_ready);
         return;
      end
      out_ready = (stall == 0);
      applyStimulus(key, pos);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (tbl_rd_en !== 1'b1 || tbl_addr !== idx) $display("[TB] FAIL %s hash_read: got rd=%b addr=%h want rd=1 addr=%h", name, tbl_rd_en, tbl_addr, idx); else passes++;
      checks++; if (hash_key !== key) $display("[TB] FAIL %s hash_key: got %h want %h", name, hash_key, key); else passes++;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL %s early_valid1: got %b want 0", name, out_valid); else passes++;
      @(negedge clk);
      checks++; if (tbl_wr_en !== 1'b1 || tbl_addr !== idx || tbl_wdata !== {1'b1, pos}) $display("[TB] FAIL %s write_back: got wr=%b addr=%h data=%h want wr=1 addr=%h data=%h", name, tbl_wr_en, tbl_addr, tbl_wdata, idx, {1'b1, pos}); else passes++;
      checks++; if (out_valid !== 1'b0 || hash_key !== 24'h0) $display("[TB] FAIL %s early_valid2: got valid=%b hash_key=%h want 0 0", name, out_valid, hash_key); else passes++;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL %s latency: got out_valid=%b want 1", name, out_valid); else passes++;
      checks++; if (out_pos !== pos) $display("[TB] FAIL %s out_pos: got %h want %h", name, out_pos, pos); else passes++;
      checks++; if (out_cand !== exp_cand) $display("[TB] FAIL %s out_cand: got %h want %h", name, out_cand, exp_cand); else passes++;
      checks++; if (out_offset !== exp_off) $display("[TB] FAIL %s out_offset: got %h want %h", name, out_offset, exp_off); else passes++;
      checks++; if (out_hit !== exp_hit) $display("[TB] FAIL %s out_hit: got %b want %b", name, out_hit, exp_hit); else passes++;
      for (int i = 1; i < stall; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("[TB] FAIL %s stall_hold: got valid=%b ready=%b want 1 0", name, out_valid, in_ready); else passes++;
         checks++; if (out_pos !== pos || out_cand !== exp_cand || out_offset !== exp_off || out_hit !== exp_hit) $display("[TB] FAIL %s stall_stable: got %h %h %h %b want %h %h %h %b", name, out_pos, out_cand, out_offset, out_hit, pos, exp_cand, exp_off, exp_hit); else passes++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL %s handshake_done: got ready=%b valid=%b want 1 0", name, in_ready, out_valid); else passes++;
      checks++; if (mem[idx] !== {1'b1, pos}) $display("[TB] FAIL %s table_entry: got %h want %h", name, mem[idx], {1'b1, pos}); else passes++;
   endtask

   // Reset values, then the full power-on clear.
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++; if (clear_busy !== 1'b1) $display("[TB] FAIL rst_clear_busy: got %b want 1", clear_busy); else passes++;
      checks++; if (tbl_wr_en !== 1'b1) $display("[TB] FAIL rst_wr_en: got %b want 1", tbl_wr_en); else passes++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); else passes++;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); else passes++;
      checks++; if (out_pos !== 16'h0 || out_cand !== 16'h0) $display("[TB] FAIL rst_out_pos_cand: got %h %h want 0 0", out_pos, out_cand); else passes++;
      checks++; if (out_offset !== 12'h0 || out_hit !== 1'b0) $display("[TB] FAIL rst_out_off_hit: got %h %b want 0 0", out_offset, out_hit); else passes++;
      checks++; if (tbl_rd_en !== 1'b0) $display("[TB] FAIL rst_rd_en: got %b want 0", tbl_rd_en); else passes++;
      checks++; if (tbl_addr !== 12'h0) $display("[TB] FAIL rst_addr: got %h want 0", tbl_addr); else passes++;
      checks++; if (tbl_wdata !== 17'h0) $display("[TB] FAIL rst_wdata: got %h want 0", tbl_wdata); else passes++;
      checks++; if (hash_key !== 24'h0) $display("[TB] FAIL rst_hash_key: got %h want 0", hash_key); else passes++;
      wait_clear_done("reset_clear");
   endtask

   // 0x434241 folds to index 0x675; first into an empty table, then again.
   task automatic test_repeat_key();
      run_key("first_key", 24'h434241, 16'd10, 16'd0, 12'd10, 1'b0, 0);
      run_key("repeat_key", 24'h434241, 16'd30, 16'd10, 12'd20, 1'b1, 0);
   endtask

   // Position counter wrap-around in both directions of the limit.
   task automatic test_wrap();
      run_key("wrap_prime", 24'h000001, 16'hFFF0, 16'h0000, 12'hFF0, 1'b0, 0);
      run_key("wrap_hit", 24'h000001, 16'h0010, 16'hFFF0, 12'h020, 1'b1, 0);
      run_key("far_prime", 24'h000002, 16'h0010, 16'h0000, 12'h010, 1'b0, 0);
      run_key("far_miss", 24'h000002, 16'h1011, 16'h0010, 12'h001, 1'b0, 0);
   endtask

   // Offset of zero is rejected; offset of exactly MAX_OFFSET is accepted.
   task automatic test_boundaries();
      run_key("zero_prime", 24'h000003, 16'h0100, 16'h0000, 12'h100, 1'b0, 0);
      run_key("zero_offset", 24'h000003, 16'h0100, 16'h0100, 12'h000, 1'b0, 0);
      run_key("max_prime", 24'h000004, 16'h0000, 16'h0000, 12'h000, 1'b0, 0);
      run_key("max_offset", 24'h000004, 16'h0FFF, 16'h0000, 12'hFFF, 1'b1, 0);
   endtask

   // Consumer holds out_ready low for 5 cycles of OUT.
   task automatic test_stall();
      run_key("stall_prime", 24'h000005, 16'h0400, 16'h0000, 12'h400, 1'b0, 0);
      run_key("stall", 24'h000005, 16'h0500, 16'h0400, 12'h100, 1'b1, 5);
   endtask

   // Reset arriving while the lookup is in RDATA.
   task automatic test_reset_in_rdata();
      applyStimulus(24'h434241, 16'h0700);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (clear_busy !== 1'b1 || tbl_addr !== 12'h0) $display("[TB] FAIL rdata_reset_restart: got busy=%b addr=%h want 1 0", clear_busy, tbl_addr); else passes++;
      checks++; if (out_valid !== 1'b0 || out_pos !== 16'h0) $display("[TB] FAIL rdata_reset_drop: got valid=%b pos=%h want 0 0", out_valid, out_pos); else passes++;
      wait_clear_done("rdata_reset_clear");
   endtask

   // clear_req and in_valid together in IDLE: the clear wins.
   task automatic test_clear_req();
      clear_req = 1'b1;
      applyStimulus(24'h000007, 16'h0800);
      #1;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL clear_req_ready: got %b want 0", in_ready); else passes++;
      @(negedge clk);
      clear_req = 1'b0;
      in_valid  = 1'b0;
      checks++; if (clear_busy !== 1'b1 || tbl_addr !== 12'h0) $display("[TB] FAIL clear_req_restart: got busy=%b addr=%h want 1 0", clear_busy, tbl_addr); else passes++;
      wait_clear_done("clear_req_clear");
   endtask

   initial begin
      test_reset();
      test_repeat_key();
      test_wrap();
      test_boundaries();
      test_stall();
      test_reset_in_rdata();
      test_clear_req();
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/lzrw1_hash_ctrl.md
# lzrw1_hash_ctrl

Sequencer for the LZRW1 match-candidate lookup. Accepts a 3-byte key and its input position, drives the combinational hash unit, performs a read-then-write on the 4096-entry pointer table, and returns the previous position stored under that hash with a validated match offset. It sits between the compressor input stage and the pointer-table RAM. After reset, and on request, it owns the table and clears it.

## Interface
- POS_W, 16, width of input byte position
- IDX_W, 12, hash index width; table depth is 2**IDX_W
- MAX_OFFSET, 4095, largest legal match offset
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear_req  in  1  request full table clear; sampled only in IDLE
- clear_busy  out  1  high while clearing
- in_valid  in  1  key/position offered
- in_ready  out  1  controller can accept a key
- in_key  in  24  3 bytes to hash; [7:0] is the first byte
- in_pos  in  POS_W  position of in_key[7:0]
- hash_key  out  24  to hash unit input
- hash_idx  in  IDX_W  from hash unit, combinational on hash_key
- tbl_addr  out  IDX_W  table address
- tbl_rd_en  out  1  read strobe; data returns the next cycle
- tbl_rdata  in  POS_W+1  {valid, pos}
- tbl_wr_en  out  1  write strobe
- tbl_wdata  out  POS_W+1  {valid, pos}
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_pos  out  POS_W  echoed in_pos
- out_cand  out  POS_W  stored position, 0 if entry invalid
- out_offset  out  12  (out_pos − out_cand) mod 2**POS_W, low 12 bits
- out_hit  out  1  entry valid and 1 ≤ offset ≤ MAX_OFFSET

## Operation
- States: CLEAR, IDLE, HASH, RDATA, OUT.
- CLEAR: write tbl_wdata=0 at tbl_addr=cnt, where cnt runs from 0 to 2**IDX_W−1, one entry per cycle. clear_busy=1, in_ready=0. After the write of the last address, go to IDLE.
- IDLE: in_ready=1. On in_valid, register key_q and pos_q, then go to HASH. If clear_req and in_valid are both high, clear_req wins: in_ready drops combinationally, the key is not taken, and the state goes to CLEAR with cnt=0.
- HASH: hash_key=key_q. Register idx_q←hash_idx. Drive tbl_rd_en=1 and tbl_addr=hash_idx. Go to RDATA.
- RDATA: capture tbl_rdata into cand. Drive tbl_wr_en=1, tbl_addr=idx_q, tbl_wdata={1,pos_q}. Register the out_* values. Go to OUT.
- OUT: hold out_valid=1 with stable data until out_ready. On the handshake cycle, return to IDLE.
- Offset arithmetic: diff = pos_q − cand, computed in POS_W bits with wrap-around. out_hit = valid & (diff ≠ 0) & (diff ≤ MAX_OFFSET). out_offset = diff[11:0]. For an invalid entry: out_cand=0, out_hit=0.
- hash_key is 0 outside HASH. The hash unit is never reset by this block.
- Reset values:
  - State goes to CLEAR with cnt=0.
  - Outputs: clear_busy=1 and tbl_wr_en=1 from the first cycle after reset. All others 0: in_ready, out_valid, out_pos, out_cand, out_offset, out_hit, tbl_rd_en, tbl_addr, tbl_wdata, hash_key.
- Reset in any state, including mid-CLEAR or OUT, abandons the current operation, drops any pending result, and restarts the clear from address 0.

## Timing
- The key is accepted on edge T (IDLE with in_valid).
- T+1: HASH, table read issued.
- T+2: RDATA, table write.
- T+3: out_valid high. Latency is 3 cycles to out_valid.
- Minimum spacing is 4 cycles per key when out_ready is held high.
- Read-before-write within one key is guaranteed. A following key to the same index sees the freshly written entry.
- Full clear takes 2**IDX_W cycles (4096) plus one cycle to reach IDLE.
- Table RAM is assumed to have 1-cycle synchronous read and a write that is visible on the next cycle.

## Structure
- Shared package lzrw1_pkg holds:
  - IDX_W, POS_W and MAX_OFFSET constants
  - state enum typedef
  - packed struct ptr_entry_t {logic valid; logic [POS_W-1:0] pos;}
- One sub-module, lzrw1_offset_check: combinational diff / hit / offset computation, reusable by the match stage.
- The hash unit and the table RAM are instantiated at top level, not inside this block.

## Test plan
- Reset released: clear_busy stays high for exactly 4096 cycles, with addresses 0..4095 each written with 0. Then in_ready=1.
- Key 0x434241 at pos 10 into an empty table: out_valid at T+3, out_hit=0, out_cand=0. Table entry hash_idx holds {1,10}.
- Same key again at pos 30: out_cand=10, out_offset=20, out_hit=1. The entry is updated to {1,30}.
- Wrap: stored pos 0xFFF0, new pos 0x0010: diff=0x0020, out_hit=1. Stored pos 0x0010, new pos 0x1011: diff=4097, out_hit=0.
- out_ready held low for 5 cycles: out_* stay stable and in_ready=0. The result completes on the first out_ready cycle, and in_ready=1 the next cycle.
- Reset asserted in RDATA, and clear_req together with in_valid in IDLE: both restart CLEAR from address 0, no out_valid appears, and the key is not accepted.
